// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Round-robin arbiter and sequencer for the shared 4-to-1 one-bit mux.
// Four requesters compete for the single mux output. One requester is granted
// at a time, and the mux select is driven from a register. An owner may keep
// the grant for as long as it keeps requesting. Once it has held the grant for
// MAX_HOLD cycles, it is moved off the grant if any other requester is
// waiting. An owner with no competitors is never moved off.
//
// Parameters:
//   MAX_HOLD   - maximum consecutive grant cycles while others wait (1..15)
//   CW         - hold counter width, 2**CW must exceed MAX_HOLD
//
// Ports:
//   i_clk      - clock, all state changes on the rising edge
//   i_rst      - synchronous active-high reset
//   i_req      - request vector, i_req[i] owns mux input d(i+1)
//   o_gnt      - registered one-hot grant, all-zero when idle
//   o_sel      - registered mux select, index of the granted requester;
//                holds its last value while idle
//   o_valid    - registered, high whenever o_gnt is non-zero
//   o_hold_cnt - saturating count of cycles the current owner has held the
//                grant (debug), zero while idle
// ---------------------------------------------------------------------------
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [3:0]    i_req,
  output logic [3:0]    o_gnt,
  output logic [1:0]    o_sel,
  output logic          o_valid,
  output logic [CW-1:0] o_hold_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_SAT   = {CW{1'b1}};

  state_t        r_state;
  logic [1:0]    r_ptr;
  logic [3:0]    r_gnt;
  logic [1:0]    r_sel;
  logic          r_valid;
  logic [CW-1:0] r_hold;

  logic [3:0]    w_otherReq;
  logic          w_ownerReq;
  logic [2:0]    w_allPick;
  logic [2:0]    w_othPick;
  logic          w_doGrant;
  logic          w_goIdle;
  logic [1:0]    w_grantIdx;

  // Searches ptr, ptr+1, ptr+2, ptr+3 (mod 4) and returns {found, index} of
  // the first set request. The 2-bit add gives the wrap-around for free.
  function automatic logic [2:0] rrPick(input logic [3:0] reqs,
                                        input logic [1:0] start);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = start;
    for (int k = 0; k < 4; k++) begin
      cand = start + 2'(k);
      if (!found && reqs[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  // While BUSY, r_sel is the owner index. Masking the owner out gives the set
  // of competitors used both for release handover and for forced rotation.
  assign w_ownerReq = i_req[r_sel];
  assign w_otherReq = i_req & ~(4'b0001 << r_sel);
  assign w_allPick  = rrPick(i_req, r_ptr);
  assign w_othPick  = rrPick(w_otherReq, r_ptr);

  // Decide whether this edge makes a new grant, drops to idle, or keeps the
  // current owner. A release with competitors hands over on the same edge,
  // so there is no idle gap.
  always_comb begin
    w_doGrant  = 1'b0;
    w_goIdle   = 1'b0;
    w_grantIdx = r_sel;
    case (r_state)
      IDLE: begin
        if (w_allPick[2]) begin
          w_doGrant  = 1'b1;
          w_grantIdx = w_allPick[1:0];
        end
      end
      BUSY: begin
        if (!w_ownerReq) begin
          if (w_othPick[2]) begin
            w_doGrant  = 1'b1;
            w_grantIdx = w_othPick[1:0];
          end else begin
            w_goIdle = 1'b1;
          end
        end else if ((r_hold >= HOLD_LIMIT) && w_othPick[2]) begin
          w_doGrant  = 1'b1;
          w_grantIdx = w_othPick[1:0];
        end
      end
      default: begin
        w_goIdle = 1'b1;
      end
    endcase
  end

  // State machine and registered outputs. Reset takes priority over every
  // other input, including an active grant. Every new grant moves the pointer
  // one past the winner, which gives the round-robin order. r_sel is left
  // untouched when going idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_ptr   <= 2'd0;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_valid <= 1'b0;
      r_hold  <= '0;
    end else if (w_doGrant) begin
      r_state <= BUSY;
      r_ptr   <= w_grantIdx + 2'd1;
      r_gnt   <= 4'b0001 << w_grantIdx;
      r_sel   <= w_grantIdx;
      r_valid <= 1'b1;
      r_hold  <= CW'(1);
    end else if (w_goIdle) begin
      r_state <= IDLE;
      r_gnt   <= 4'b0000;
      r_valid <= 1'b0;
      r_hold  <= '0;
    end else if ((r_state == BUSY) && (r_hold != HOLD_SAT)) begin
      r_hold <= r_hold + CW'(1);
    end
  end

  assign o_gnt      = r_gnt;
  assign o_sel      = r_sel;
  assign o_valid    = r_valid;
  assign o_hold_cnt = r_hold;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//
// Directed self-checking bench for mux4_rr_arbiter, built with MAX_HOLD=3 so
// that forced rotation shows up quickly. Each expected value is hand-derived
// from the arbitration rules. Inputs change 1 time unit after a rising edge,
// and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic [3:0] holdCnt;

  int checks   = 0;
  int failures = 0;

  mux4_rr_arbiter #(
    .MAX_HOLD(3),
    .CW      (4)
  ) dut (
    .i_clk     (clock),
    .i_rst     (reset),
    .i_req     (req),
    .o_gnt     (gnt),
    .o_sel     (sel),
    .o_valid   (valid),
    .o_hold_cnt(holdCnt)
  );

  // 10-unit clock period
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Drive one set of inputs, then advance past the next rising edge
  task automatic applyStimulus(input logic [3:0] reqVal, input logic rstVal);
    req   = reqVal;
    reset = rstVal;
    @(posedge clock);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Owner sequence for four continuous requesters with MAX_HOLD=3
  int         rotSeq[13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  logic [3:0] expGnt;

  initial begin
    req   = 4'b0000;
    reset = 1'b1;

    // Reset held for two edges while every requester is asking
    applyStimulus(4'b1111, 1'b1);
    applyStimulus(4'b1111, 1'b1);
    checkOutput("reset_gnt",   gnt,     4'b0000);
    checkOutput("reset_sel",   sel,     2'b00);
    checkOutput("reset_valid", valid,   1'b0);
    checkOutput("reset_hold",  holdCnt, 4'd0);

    // First grant after reset follows ptr=0; ptr moves to 1
    applyStimulus(4'b1111, 1'b0);
    checkOutput("post_reset_gnt",   gnt,     4'b0001);
    checkOutput("post_reset_sel",   sel,     2'b00);
    checkOutput("post_reset_valid", valid,   1'b1);
    checkOutput("post_reset_hold",  holdCnt, 4'd1);

    // Everyone drops out, so the arbiter goes idle and sel stays put
    applyStimulus(4'b0000, 1'b0);
    checkOutput("idle_gnt",   gnt,   4'b0000);
    checkOutput("idle_valid", valid, 1'b0);
    checkOutput("idle_sel",   sel,   2'b00);

    // Single requester: never forced off, hold count saturates at 15
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(4'b0100, 1'b0);
      checkOutput($sformatf("single_gnt_%0d", k),  gnt,     4'b0100);
      checkOutput($sformatf("single_sel_%0d", k),  sel,     2'b10);
      checkOutput($sformatf("single_hold_%0d", k), holdCnt, (k > 15) ? 15 : k);
    end

    // Release handover starting from ptr=0
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b1010, 1'b0);
    checkOutput("handover_first_gnt", gnt, 4'b0010);
    checkOutput("handover_first_sel", sel, 2'b01);
    applyStimulus(4'b1000, 1'b0);
    checkOutput("handover_next_gnt",   gnt,     4'b1000);
    checkOutput("handover_next_sel",   sel,     2'b11);
    checkOutput("handover_next_valid", valid,   1'b1);
    checkOutput("handover_next_hold",  holdCnt, 4'd1);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("handover_idle_gnt",   gnt,   4'b0000);
    checkOutput("handover_idle_valid", valid, 1'b0);
    checkOutput("handover_idle_sel",   sel,   2'b11);

    // Forced rotation with four continuous requesters
    applyStimulus(4'b0000, 1'b1);
    for (int i = 0; i < 13; i++) begin
      applyStimulus(4'b1111, 1'b0);
      expGnt = 4'b0001 << rotSeq[i];
      checkOutput($sformatf("rotate_gnt_%0d", i), gnt, expGnt);
      checkOutput($sformatf("rotate_sel_%0d", i), sel, rotSeq[i]);
    end

    // Wrap-around: granting 2 leaves ptr=3, then 3 wins before 0
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("wrap_setup_gnt", gnt, 4'b0100);
    applyStimulus(4'b1001, 1'b0);
    checkOutput("wrap_first_gnt", gnt, 4'b1000);
    checkOutput("wrap_first_sel", sel, 2'b11);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("wrap_second_gnt", gnt, 4'b0001);
    checkOutput("wrap_second_sel", sel, 2'b00);

    // Reset mid-grant: the owner is dropped on the reset edge itself
    applyStimulus(4'b0100, 1'b0);
    checkOutput("midrst_setup_gnt", gnt, 4'b0100);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("midrst_gnt",   gnt,     4'b0000);
    checkOutput("midrst_hold",  holdCnt, 4'd0);
    checkOutput("midrst_valid", valid,   1'b0);
    checkOutput("midrst_sel",   sel,     2'b00);
    applyStimulus(4'b0110, 1'b0);
    checkOutput("midrst_regrant_gnt", gnt, 4'b0010);
    checkOutput("midrst_regrant_sel", sel, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and sequencer for the shared 4-to-1 one-bit mux (`mux4to1`). Four requesters compete for the single mux output. The block grants one requester at a time and drives the mux `sel` from a register. An owner may hold the grant while it keeps requesting, up to a bounded burst; after that the grant is forced to rotate if anyone else is waiting.

## Interface
Parameters:
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per owner while another requester waits. Legal range 1..15.
- `CW`, default 4: width of the hold counter. Must satisfy `2**CW > MAX_HOLD`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req`, input, 4: request vector; `req[i]` corresponds to mux input `d(i+1)`.
- `gnt`, output, 4: one-hot grant, or all-zero when idle; registered.
- `sel`, output, 2: mux select, equal to the index of the granted requester; registered.
- `valid`, output, 1: high when `gnt` is non-zero, meaning the mux output is owned this cycle.
- `hold_cnt`, output, CW: cycles the current owner has held the grant, saturating; for debug.

## Operation
- State machine with two states:
  - IDLE: `gnt=0`, `valid=0`.
  - BUSY: exactly one `gnt` bit set, `valid=1`.
- Round-robin pointer `ptr[1:0]`:
  - The search order is `ptr, ptr+1, ptr+2, ptr+3`, mod 4 (wrap-around 3→0).
  - The first requester found with `req` high wins.
  - On every new grant to index `w`, `ptr` becomes `w+1` mod 4.
- IDLE transitions:
  - If `req != 0`, grant the winner and go to BUSY with `hold_cnt=1`.
  - Otherwise stay in IDLE.
- BUSY transitions, evaluated for owner `o`:
  - **Release:** `req[o]=0`.
    - Arbitrate among the remaining requesters (`req` with bit `o` masked).
    - If there is a winner, grant it with no idle cycle and set `hold_cnt=1`.
    - If there is none, go to IDLE, `gnt=0`, `sel` unchanged.
  - **Forced rotate:** `req[o]=1`, `hold_cnt >= MAX_HOLD`, and some other `req` is high.
    - Grant the round-robin winner with `o` excluded; set `hold_cnt=1`.
  - **Continue:** `req[o]=1` and no rotate.
    - Keep the grant. `hold_cnt` increments and saturates at `2**CW-1`.
    - An owner with no competitors is never forced off.
- `sel` updates only together with a new grant; in IDLE it keeps its last value.
- Invariants:
  - `gnt` is always zero or one-hot.
  - `valid == |gnt`.
  - Whenever `valid=1`, `gnt == (4'b0001 << sel)`.

## Timing
- Reset values on the first edge with `rst=1`: `gnt=4'b0000`, `sel=2'b00`, `valid=0`, `hold_cnt=0`, `ptr=0`, state IDLE.
  - Reset overrides all other inputs.
  - Reset asserted mid-grant drops `gnt` on that same edge.
- Request-to-grant latency is 1 cycle. `req` sampled at edge N produces `gnt` and `sel` visible after edge N.
- Handover on release takes 1 edge with no bubble. The old owner's `gnt` falls and the new owner's `gnt` rises on the same edge.
- Simultaneous requests are resolved by `ptr` alone; there is no fixed priority.
- A requester dropping `req` while not granted has no effect.
- A requester raising `req` on the same edge as a release is eligible for that handover.
- With 4 continuous requesters and `MAX_HOLD=M`, each owner gets exactly M cycles, in order 0,1,2,3,0,…

## Test plan
- **Reset:** hold `rst=1` for 2 cycles with `req=4'b1111`. Then `gnt=0`, `sel=0`, `valid=0`. Release reset → one edge later `gnt=4'b0001`, `sel=2'b00`.
- **Single requester:** `req=4'b0100` for 20 cycles. Then `gnt=4'b0100` and `sel=2'b10` for all 20 cycles, with no forced rotation. `hold_cnt` saturates at 15.
- **Release handover:** starting from `ptr=0`, apply `req=4'b1010` → `gnt=4'b0010`. Drop `req[1]` → next edge `gnt=4'b1000`, `sel=2'b11`, with no `valid=0` gap. Drop `req[3]` → IDLE, `sel` stays at `2'b11`.
- **Forced rotation:** `MAX_HOLD=3`, `req=4'b1111` held. The grant sequence per cycle is 0,0,0,1,1,1,2,2,2,3,3,3,0. `sel` tracks it and `gnt` stays one-hot every cycle.
- **Wrap-around fairness:** with `ptr=3` (after granting 2), apply `req=4'b1001` → grant goes to 3, then 0 on release. Requester 0 is not starved.
- **Reset mid-grant:** while `gnt=4'b0100`, pulse `rst` for 1 cycle. Next edge `gnt=0`, `hold_cnt=0`. The first grant after reset follows `ptr=0` (for `req=4'b0110`, grant `4'b0010`).
